// File: rtl/demultiplexer_bus_8_hs.sv
`default_nettype none
// ============================================================================
// Module   : demultiplexer_bus_8_hs
// Brief    : Registered 1-to-8 bus demux, valid/ready on input and each output.
// Revision : 1.0 - initial release
// ============================================================================
module demultiplexer_bus_8_hs #(
  parameter int NrOfBits = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic                Flush,
  input  logic [NrOfBits-1:0] DemuxIn,
  input  logic [2:0]          Sel,
  input  logic                InValid,
  output logic                InReady,
  output logic [NrOfBits-1:0] DemuxOut_0,
  output logic [NrOfBits-1:0] DemuxOut_1,
  output logic [NrOfBits-1:0] DemuxOut_2,
  output logic [NrOfBits-1:0] DemuxOut_3,
  output logic [NrOfBits-1:0] DemuxOut_4,
  output logic [NrOfBits-1:0] DemuxOut_5,
  output logic [NrOfBits-1:0] DemuxOut_6,
  output logic [NrOfBits-1:0] DemuxOut_7,
  output logic [7:0]          OutValid,
  input  logic [7:0]          OutReady,
  output logic [2:0]          LastSel
);

  logic [NrOfBits-1:0] data_q [8];
  logic [NrOfBits-1:0] data_d [8];
  logic [7:0]          valid_q, valid_d;
  logic [2:0]          last_sel_q, last_sel_d;
  logic                accept;

  // A full slot can still take a word when its consumer drains it this cycle.
  assign InReady = Reset_n & Enable & ~Flush & (~valid_q[Sel] | OutReady[Sel]);
  assign accept  = InValid & InReady;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q & ~OutReady;
    last_sel_d = last_sel_q;
    if (Flush) begin
      valid_d = 8'h00;
    end else if (accept) begin
      data_d[Sel]  = DemuxIn;
      valid_d[Sel] = 1'b1;
      last_sel_d   = Sel;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int k = 0; k < 8; k++) data_q[k] <= '0;
      valid_q    <= 8'h00;
      last_sel_q <= 3'b000;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_sel_q <= last_sel_d;
    end
  end

  assign DemuxOut_0 = data_q[0];
  assign DemuxOut_1 = data_q[1];
  assign DemuxOut_2 = data_q[2];
  assign DemuxOut_3 = data_q[3];
  assign DemuxOut_4 = data_q[4];
  assign DemuxOut_5 = data_q[5];
  assign DemuxOut_6 = data_q[6];
  assign DemuxOut_7 = data_q[7];
  assign OutValid   = valid_q;
  assign LastSel    = last_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_demultiplexer_bus_8_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_demultiplexer_bus_8_hs
// Brief    : Bench for demultiplexer_bus_8_hs: slot model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_demultiplexer_bus_8_hs;

  logic       clk = 1'b0;
  logic       rst_n, en, flush, in_valid;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] out_ready;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [2:0] last_sel;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] dout [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: eight one-word slots, each either holding a word or empty.
  logic [7:0] m_word [8];
  bit         m_full [8];
  logic [2:0] m_last;
  bit         model_ok = 0;

  always #5 clk = ~clk;

  demultiplexer_bus_8_hs #(.NrOfBits(8)) dut (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Flush(flush),
    .DemuxIn(din), .Sel(sel), .InValid(in_valid), .InReady(in_ready),
    .DemuxOut_0(d0), .DemuxOut_1(d1), .DemuxOut_2(d2), .DemuxOut_3(d3),
    .DemuxOut_4(d4), .DemuxOut_5(d5), .DemuxOut_6(d6), .DemuxOut_7(d7),
    .OutValid(out_valid), .OutReady(out_ready), .LastSel(last_sel)
  );

  assign dout[0] = d0; assign dout[1] = d1; assign dout[2] = d2; assign dout[3] = d3;
  assign dout[4] = d4; assign dout[5] = d5; assign dout[6] = d6; assign dout[7] = d7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return rst_n && en && !flush && (!m_full[sel] || out_ready[sel]);
  endfunction

  function automatic logic [7:0] model_valid_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin m_word[k] = 8'h00; m_full[k] = 0; end
      m_last   = 3'd0;
      model_ok = 1;
    end else if (flush) begin
      for (int k = 0; k < 8; k++) m_full[k] = 0;
    end else begin
      bit take;
      take = in_valid && en && (!m_full[sel] || out_ready[sel]);
      for (int k = 0; k < 8; k++) if (out_ready[k]) m_full[k] = 0;
      if (take) begin
        m_word[sel] = din;
        m_full[sel] = 1;
        m_last      = sel;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("OutValid", {24'd0, out_valid}, {24'd0, model_valid_vec()});
      chk("LastSel", {29'd0, last_sel}, {29'd0, m_last});
      chk("InReady", {31'd0, in_ready}, {31'd0, model_ready()});
      for (int k = 0; k < 8; k++)
        chk($sformatf("DemuxOut_%0d", k), {24'd0, dout[k]}, {24'd0, m_word[k]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; en = 0; flush = 0; in_valid = 0; din = 0; sel = 0; out_ready = 0;
    cyc(); cyc();
    chk("rst_OutValid", {24'd0, out_valid}, 32'h00);
    chk("rst_LastSel", {29'd0, last_sel}, 32'd0);
    chk("rst_Out3", {24'd0, d3}, 32'h00);
    chk("rst_InReady", {31'd0, in_ready}, 32'd0);

    // single accept then drain
    rst_n = 1; en = 1; in_valid = 1; sel = 3; din = 8'hA5;
    cyc(); in_valid = 0;
    chk("t1_OutValid", {24'd0, out_valid}, 32'h08);
    chk("t1_Out3", {24'd0, d3}, 32'hA5);
    chk("t1_LastSel", {29'd0, last_sel}, 32'd3);
    out_ready = 8'h08;
    cyc(); out_ready = 8'h00;
    chk("t1_drain_OutValid", {24'd0, out_valid}, 32'h00);
    chk("t1_drain_Out3", {24'd0, d3}, 32'hA5);

    // backpressure on full channel 5
    in_valid = 1; sel = 5; din = 8'h55;
    cyc();
    din = 8'h11; #1;
    chk("t2_InReady_blocked", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t2_Out5_held", {24'd0, d5}, 32'h55);
    sel = 2; #1;
    chk("t2_InReady_ch2", {31'd0, in_ready}, 32'd1);
    cyc(); in_valid = 0;
    chk("t2_OutValid", {24'd0, out_valid}, 32'h24);
    chk("t2_Out2", {24'd0, d2}, 32'h11);
    out_ready = 8'hFF; cyc(); out_ready = 8'h00;

    // full-throughput streaming into channel 0
    in_valid = 1; sel = 0; din = 8'h00;
    cyc();
    out_ready = 8'h01;
    for (int v = 1; v <= 3; v++) begin
      din = v[7:0]; #1;
      chk("t3_InReady", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("t3_Out0", {24'd0, d0}, v);
      chk("t3_Valid0", {31'd0, out_valid[0]}, 32'd1);
    end
    in_valid = 0; cyc(); out_ready = 8'h00;

    // fill all, then flush
    in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      sel = k[2:0]; din = 8'h10 + k[7:0];
      cyc();
    end
    chk("t4_full", {24'd0, out_valid}, 32'hFF);
    flush = 1; sel = 4; #1;
    chk("t4_InReady_flush", {31'd0, in_ready}, 32'd0);
    cyc(); flush = 0; in_valid = 0;
    chk("t4_OutValid", {24'd0, out_valid}, 32'h00);
    chk("t4_Out4", {24'd0, d4}, 32'h14);

    // disabled input still drains
    in_valid = 1; sel = 6; din = 8'h66;
    cyc(); in_valid = 0;
    en = 0; out_ready = 8'h40;
    sel = 0; #1; chk("t5_InReady_s0", {31'd0, in_ready}, 32'd0);
    sel = 6; #1; chk("t5_InReady_s6", {31'd0, in_ready}, 32'd0);
    sel = 7; #1; chk("t5_InReady_s7", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t5_OutValid", {24'd0, out_valid}, 32'h00);
    en = 1; out_ready = 8'h00;

    // reset mid-stream
    in_valid = 1; sel = 1; din = 8'h71; cyc();
    sel = 7; din = 8'h77; cyc();
    rst_n = 0; sel = 2; din = 8'h99; #1;
    chk("t6_InReady_rst", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t6_OutValid", {24'd0, out_valid}, 32'h00);
    chk("t6_Out1", {24'd0, d1}, 32'h00);
    chk("t6_Out7", {24'd0, d7}, 32'h00);
    chk("t6_LastSel", {29'd0, last_sel}, 32'd0);
    rst_n = 1; #1;
    chk("t6_InReady_after", {31'd0, in_ready}, 32'd1);
    cyc(); in_valid = 0;
    chk("t6_first_accept", {24'd0, out_valid}, 32'h04);
    chk("t6_Out2", {24'd0, d2}, 32'h99);
    chk("t6_LastSel2", {29'd0, last_sel}, 32'd2);

    // randomized traffic against the slot model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      din       = 8'($urandom);
      out_ready = 8'($urandom) & 8'($urandom);
      cyc();
    end

    rst_n = 1; flush = 0; in_valid = 0;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
